// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change dispenser.
package vend_pkg;

  localparam int unsigned NumDenom = 4;

  // Coin values, index 0 is the largest denomination.
  localparam int unsigned DENOM [NumDenom] = '{50, 10, 5, 1};

  typedef logic [7:0] money_t;
  typedef logic [1:0] prod_t;

  typedef enum logic [2:0] {
    StIdle,
    StDrop,
    StSelect,
    StIssue,
    StDone,
    StFault
  } state_t;

endpackage

// File: rtl/vend_coin_pick.sv
// Combinational greedy coin selector: lowest index (largest value) that fits and is stocked.
module vend_coin_pick
  import vend_pkg::*;
#(
  parameter int unsigned D0 = DENOM[0],
  parameter int unsigned D1 = DENOM[1],
  parameter int unsigned D2 = DENOM[2],
  parameter int unsigned D3 = DENOM[3]
) (
  input  money_t            i_rem,
  input  logic [NumDenom-1:0] i_inv_nz,
  output logic [1:0]        o_k,
  output logic              o_found
);

  localparam money_t DV [NumDenom] = '{money_t'(D0), money_t'(D1), money_t'(D2), money_t'(D3)};

  // Scan from smallest to largest so the lowest qualifying index wins.
  always_comb begin
    o_k     = '0;
    o_found = 1'b0;
    for (int i = NumDenom - 1; i >= 0; i--) begin
      if (i_inv_nz[i] && (DV[i] <= i_rem)) begin
        o_k     = 2'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Drops the product, then pays change one coin at a time from a tracked coin inventory.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned D0    = DENOM[0],
  parameter int unsigned D1    = DENOM[1],
  parameter int unsigned D2    = DENOM[2],
  parameter int unsigned D3    = DENOM[3],
  parameter int unsigned INV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  money_t           chg_in,
  input  prod_t            prod_in,
  input  logic             inv_ld,
  input  logic [1:0]       inv_sel,
  input  logic [INV_W-1:0] inv_val,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output prod_t            prod_drop,
  output logic             done,
  output logic             fault,
  output money_t           short_amt,
  input  logic             fault_clr
);

  localparam money_t DV [NumDenom] = '{money_t'(D0), money_t'(D1), money_t'(D2), money_t'(D3)};

  state_t           r_state, w_state_d;
  money_t           r_rem, w_rem_d;
  prod_t            r_prod, w_prod_d;
  logic [INV_W-1:0] r_inv [NumDenom];
  logic [1:0]       r_coin_type, w_coin_type_d;
  logic             r_coin_valid, r_done, r_fault, r_in_ready;
  prod_t            r_prod_drop;
  money_t           r_short_amt;

  logic [NumDenom-1:0] w_inv_nz;
  logic [1:0]          w_k;
  logic                w_found;
  logic                w_inv_dec;
  logic                w_inv_load;

  // Flag stocked denominations for the selector.
  always_comb begin
    w_inv_nz = '0;
    for (int i = 0; i < NumDenom; i++) begin
      w_inv_nz[i] = (r_inv[i] != '0);
    end
  end

  vend_coin_pick #(
    .D0 (D0),
    .D1 (D1),
    .D2 (D2),
    .D3 (D3)
  ) u_pick (
    .i_rem    (r_rem),
    .i_inv_nz (w_inv_nz),
    .o_k      (w_k),
    .o_found  (w_found)
  );

  assign w_inv_dec  = (r_state == StIssue) && coin_ack;
  assign w_inv_load = (r_state == StIdle) && inv_ld;

  // Next-state, remainder and coin-type selection.
  always_comb begin
    w_state_d     = r_state;
    w_rem_d       = r_rem;
    w_prod_d      = r_prod;
    w_coin_type_d = r_coin_type;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_rem_d   = chg_in;
          w_prod_d  = prod_in;
          w_state_d = (prod_in != '0) ? StDrop : StSelect;
        end
      end
      StDrop: w_state_d = StSelect;
      StSelect: begin
        if (r_rem == '0) begin
          w_state_d = StDone;
        end else if (w_found) begin
          w_coin_type_d = w_k;
          w_state_d     = StIssue;
        end else begin
          w_state_d = StFault;
        end
      end
      StIssue: begin
        if (coin_ack) begin
          w_rem_d   = r_rem - DV[r_coin_type];
          w_state_d = StSelect;
        end
      end
      StDone: w_state_d = StIdle;
      StFault: begin
        if (fault_clr) begin
          w_rem_d   = '0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_rem        <= '0;
      r_prod       <= '0;
      r_coin_type  <= '0;
      r_coin_valid <= 1'b0;
      r_prod_drop  <= '0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_short_amt  <= '0;
      r_in_ready   <= 1'b1;
      for (int i = 0; i < NumDenom; i++) begin
        r_inv[i] <= '0;
      end
    end else begin
      r_state      <= w_state_d;
      r_rem        <= w_rem_d;
      r_prod       <= w_prod_d;
      r_coin_type  <= w_coin_type_d;
      r_coin_valid <= (w_state_d == StIssue);
      r_prod_drop  <= (w_state_d == StDrop) ? w_prod_d : '0;
      r_done       <= (w_state_d == StDone);
      r_fault      <= (w_state_d == StFault);
      r_short_amt  <= (w_state_d == StFault) ? w_rem_d : '0;
      r_in_ready   <= (w_state_d == StIdle);
      if (w_inv_dec) begin
        r_inv[r_coin_type] <= r_inv[r_coin_type] - INV_W'(1);
      end else if (w_inv_load) begin
        r_inv[inv_sel] <= inv_val;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign coin_valid = r_coin_valid;
  assign coin_type  = r_coin_type;
  assign prod_drop  = r_prod_drop;
  assign done       = r_done;
  assign fault      = r_fault;
  assign short_amt  = r_short_amt;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Scoreboard bench: a greedy payout model predicts drop/coin/done/fault events; a monitor checks them.
module tb_vend_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] chg_in = '0;
  logic [1:0] prod_in = '0;
  logic       inv_ld = 1'b0;
  logic [1:0] inv_sel = '0;
  logic [7:0] inv_val = '0;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ack = 1'b0;
  logic [1:0] prod_drop;
  logic       done;
  logic       fault;
  logic [7:0] short_amt;
  logic       fault_clr = 1'b0;

  vend_change_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .chg_in     (chg_in),
    .prod_in    (prod_in),
    .inv_ld     (inv_ld),
    .inv_sel    (inv_sel),
    .inv_val    (inv_val),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .coin_ack   (coin_ack),
    .prod_drop  (prod_drop),
    .done       (done),
    .fault      (fault),
    .short_amt  (short_amt),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 drop, 1 coin accepted, 2 done, 3 fault raised.
  typedef struct {
    int kind;
    int val;
    int lat;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  cap_cyc = 0;
  int  m_inv [4];
  int  m_short = 0;
  int  ack_mode = 0;  // 0 tied high, 1 random, 2 driven by the test
  logic prev_fault = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) coin_ack = 1'b1;
    else if (ack_mode == 1) coin_ack = ($urandom_range(0, 2) == 0);
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_errors++;
        $display("FAIL event: got kind %0d val %0d expected kind %0d val %0d",
                 kind, val, e.kind, e.val);
      end
      if (e.lat >= 0) check("event_latency", cyc - cap_cyc, e.lat);
    end
  endtask

  // Monitor: compare every observable output event against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (prod_drop != 2'd0) check_ev(0, int'(prod_drop));
      if (coin_valid && coin_ack) check_ev(1, int'(coin_type));
      if (done) check_ev(2, 0);
      if (fault && !prev_fault) check_ev(3, int'(short_amt));
    end
    prev_fault <= fault;
  end

  // Reference: greedy largest-first payout from the model inventory.
  task automatic model_txn(input int chg, input int prod);
    int dv [4] = '{50, 10, 5, 1};
    int rem = chg;
    int n = 0;
    int d = (prod != 0) ? 1 : 0;
    int best;
    bit fixed = (ack_mode == 0);
    if (prod != 0) exp_q.push_back('{0, prod, 1});
    while (rem > 0) begin
      best = -1;
      for (int i = 0; i < 4; i++) begin
        if (best < 0 && dv[i] <= rem && m_inv[i] > 0) best = i;
      end
      if (best < 0) break;
      n++;
      exp_q.push_back('{1, best, fixed ? d + 2 * n : -1});
      m_inv[best]--;
      rem -= dv[best];
    end
    m_short = rem;
    if (rem > 0) exp_q.push_back('{3, rem, -1});
    else exp_q.push_back('{2, 0, fixed ? d + 2 * n + 2 : -1});
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic load_inv(input int sel, input int val);
    wait_ready();
    @(posedge clk); #1;
    inv_ld = 1'b1; inv_sel = 2'(sel); inv_val = 8'(val);
    @(posedge clk); #1;
    inv_ld = 1'b0;
    m_inv[sel] = val;
  endtask

  task automatic start_txn(input int chg, input int prod, input bit ld, input int sel,
                           input int val);
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b1; chg_in = 8'(chg); prod_in = 2'(prod);
    if (ld) begin
      inv_ld = 1'b1; inv_sel = 2'(sel); inv_val = 8'(val);
      m_inv[sel] = val;
    end
    model_txn(chg, prod);
    @(negedge clk);
    cap_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; inv_ld = 1'b0;
  endtask

  task automatic finish_txn();
    int t = 0;
    @(negedge clk);
    while (!done && !fault && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!done && !fault) begin
      check("txn_timeout", 0, 1);
    end else if (fault) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("fault_held", int'(fault), 1);
        check("short_held", int'(short_amt), m_short);
      end
      @(posedge clk); #1; fault_clr = 1'b1;
      @(posedge clk); #1; fault_clr = 1'b0;
      @(negedge clk);
      check("clr_fault", int'(fault), 0);
      check("clr_short", int'(short_amt), 0);
      check("clr_ready", int'(in_ready), 1);
    end
  endtask

  task automatic check_inv();
    for (int i = 0; i < 4; i++) check("inventory", int'(dut.r_inv[i]), m_inv[i]);
  endtask

  task automatic wait_coin_valid();
    int t = 0;
    @(negedge clk);
    while (!coin_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!coin_valid) check("coin_valid_timeout", 0, 1);
  endtask

  initial begin
    int t_type;
    int t_rem;
    for (int i = 0; i < 4; i++) m_inv[i] = 0;
    #2 rst = 1'b0;
    #6;
    check("rst_ready", int'(in_ready), 1);
    check("rst_coin_valid", int'(coin_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_short", int'(short_amt), 0);
    #15 rst = 1'b1;

    // Greedy payout 65 with product 2.
    ack_mode = 0;
    for (int i = 0; i < 4; i++) load_inv(i, 10);
    start_txn(65, 2, 0, 0, 0);
    finish_txn();
    check_inv();
    check("t1_inv0", int'(dut.r_inv[0]), 9);
    check("t1_inv3", int'(dut.r_inv[3]), 10);

    // Fallback to smaller coins.
    load_inv(0, 0); load_inv(1, 2); load_inv(2, 0); load_inv(3, 3);
    start_txn(23, 1, 0, 0, 0);
    finish_txn();
    check_inv();

    // Fault path: 55 with 1x50 and 2x1.
    load_inv(0, 1); load_inv(1, 0); load_inv(2, 0); load_inv(3, 2);
    start_txn(55, 0, 0, 0, 0);
    finish_txn();
    check("t3_short_model", m_short, 3);
    check_inv();

    // Zero change, no product.
    start_txn(0, 0, 0, 0, 0);
    finish_txn();

    // Hopper stall for 5 cycles; inv_ld during payment is ignored.
    load_inv(1, 3);
    ack_mode = 2;
    coin_ack = 1'b0;
    start_txn(10, 0, 0, 0, 0);
    wait_coin_valid();
    t_type = int'(coin_type);
    t_rem  = int'(dut.r_rem);
    check("stall_type", t_type, 1);
    @(posedge clk); #1;
    inv_ld = 1'b1; inv_sel = 2'd3; inv_val = 8'd77;
    @(posedge clk); #1;
    inv_ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", int'(coin_valid), 1);
      check("stall_type_stable", int'(coin_type), t_type);
      check("stall_rem", int'(dut.r_rem), t_rem);
      check("stall_inv", int'(dut.r_inv[1]), 3);
    end
    @(posedge clk); #1; coin_ack = 1'b1;
    @(posedge clk); #1; coin_ack = 1'b0;
    ack_mode = 0;
    finish_txn();
    check_inv();

    // Asynchronous reset while a coin is outstanding.
    for (int i = 0; i < 4; i++) load_inv(i, 5);
    ack_mode = 2;
    coin_ack = 1'b0;
    start_txn(30, 0, 0, 0, 0);
    wait_coin_valid();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("arst_coin_valid", int'(coin_valid), 0);
    check("arst_coin_type", int'(coin_type), 0);
    check("arst_prod_drop", int'(prod_drop), 0);
    check("arst_done", int'(done), 0);
    check("arst_fault", int'(fault), 0);
    check("arst_short", int'(short_amt), 0);
    check("arst_ready", int'(in_ready), 1);
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_inv[i] = 0;
    #10 rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(in_ready), 1);
    check_inv();

    // Load and capture in the same cycle; spurious ack in IDLE.
    ack_mode = 0;
    start_txn(5, 0, 1, 2, 1);
    finish_txn();
    check_inv();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ack_ready", int'(in_ready), 1);
      check("idle_ack_valid", int'(coin_valid), 0);
    end
    check_inv();

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      ack_mode = int'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) load_inv(i, int'($urandom_range(0, 6)));
      end
      start_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 0, 0, 0);
      finish_txn();
      check_inv();
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
